// File: rtl/exp5_sonar.sv
// exp5_sonar: sonar sweep controller. Steps a servo through 8 angles, ranges an
// HC-SR04 at each one, reports "AAA,DDD#" over a 7O2 UART and shows the last
// distance/angle on six active-low 7-segment displays.
// Optional feature: define SONAR_TIMEOUT_EN to abandon an echo wait after TIMEOUT
// cycles and report distance 999.
module exp5_sonar #(
  parameter int unsigned TIME        = 10_000_000,
  parameter int unsigned TIMEOUT     = 1_500_000,
  parameter int unsigned TRIG_CYCLES = 500,
  parameter int unsigned BIT_CYCLES  = 434,
  parameter int unsigned CM_DIV      = 2941,
  parameter int unsigned CM_HALF     = 1470,
  parameter int unsigned PWM_PERIOD  = 1_000_000,
  parameter int unsigned PWM_MIN     = 50_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       echo,
  output logic       trigger,
  output logic       pwm,
  output logic       saida_serial,
  output logic       fim_posicao,
  output logic [6:0] display0,
  output logic [6:0] display1,
  output logic [6:0] display2,
  output logic [6:0] display3,
  output logic [6:0] display4,
  output logic [6:0] display5
);

  localparam int unsigned CMAX0 = (TIME > TIMEOUT) ? TIME : TIMEOUT;
  localparam int unsigned CMAX  = (CMAX0 > TRIG_CYCLES) ? CMAX0 : TRIG_CYCLES;
  localparam int unsigned CW    = $clog2(CMAX + 1);
  localparam int unsigned BW    = $clog2(BIT_CYCLES);
  localparam int unsigned PRW   = $clog2(CM_DIV);
  localparam int unsigned PW    = $clog2(PWM_PERIOD);

  typedef enum logic [2:0] {
    S_IDLE, S_POSICIONA, S_TRIGGER, S_ESPERA_ECHO, S_MEDE, S_TRANSMITE, S_FIM
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            echo_m, echo_s, echo_d, echo_rise;
  logic            timeout_c;
  logic [PRW-1:0]  presc;
  logic [11:0]     cm_bcd, dist_bcd, ang_bcd, dist_nx_c;
  logic [2:0]      idx, idx_nx_c, ang_idx_c;
  logic            dir_up, dir_nx_c;
  logic [PW-1:0]   pwm_cnt, pwm_hi;
  logic [10:0]     tx_sh;
  logic [3:0]      tx_bit;
  logic [BW-1:0]   tx_baud;
  logic [2:0]      tx_chr;
  logic            tx_bit_end, tx_done_c;
  logic            ld_angle_c, meas_start_c, latch_c, adv_c;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Three-digit BCD increment that holds at 999.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] != 4'd9) r[3:0] = v[3:0] + 4'd1;
      else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) r[7:4] = v[7:4] + 4'd1;
        else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [11:0] ang_of(input logic [2:0] i);
    case (i)
      3'd0:    return 12'h020;
      3'd1:    return 12'h040;
      3'd2:    return 12'h060;
      3'd3:    return 12'h080;
      3'd4:    return 12'h100;
      3'd5:    return 12'h120;
      3'd6:    return 12'h140;
      default: return 12'h160;
    endcase
  endfunction

  // Servo high time: PWM_MIN + angle * PWM_MIN / 180, folded per angle.
  function automatic logic [PW-1:0] high_of(input logic [2:0] i);
    case (i)
      3'd0:    return PW'(PWM_MIN + (20  * PWM_MIN) / 180);
      3'd1:    return PW'(PWM_MIN + (40  * PWM_MIN) / 180);
      3'd2:    return PW'(PWM_MIN + (60  * PWM_MIN) / 180);
      3'd3:    return PW'(PWM_MIN + (80  * PWM_MIN) / 180);
      3'd4:    return PW'(PWM_MIN + (100 * PWM_MIN) / 180);
      3'd5:    return PW'(PWM_MIN + (120 * PWM_MIN) / 180);
      3'd6:    return PW'(PWM_MIN + (140 * PWM_MIN) / 180);
      default: return PW'(PWM_MIN + (160 * PWM_MIN) / 180);
    endcase
  endfunction

  function automatic logic [6:0] tx_char(input logic [2:0] k, input logic [11:0] a,
                                         input logic [11:0] d);
    case (k)
      3'd0:    return 7'h30 | {3'b000, a[11:8]};
      3'd1:    return 7'h30 | {3'b000, a[7:4]};
      3'd2:    return 7'h30 | {3'b000, a[3:0]};
      3'd3:    return 7'h2C;
      3'd4:    return 7'h30 | {3'b000, d[11:8]};
      3'd5:    return 7'h30 | {3'b000, d[7:4]};
      3'd6:    return 7'h30 | {3'b000, d[3:0]};
      default: return 7'h23;
    endcase
  endfunction

  // 7O2 frame, LSB shifted out first: start, data, odd parity, two stops.
  function automatic logic [10:0] tx_frame(input logic [6:0] c);
    return {2'b11, ~^c, c, 1'b0};
  endfunction

  assign echo_rise  = echo_s & ~echo_d;
  assign tx_bit_end = (tx_baud == BW'(BIT_CYCLES - 1));
  assign tx_done_c  = (state == S_TRANSMITE) && tx_bit_end && (tx_bit == 4'd10) && (tx_chr == 3'd7);

`ifdef SONAR_TIMEOUT_EN
  assign timeout_c = (cnt == CW'(TIMEOUT - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:        if (ligar) state_nx = S_POSICIONA;
      S_POSICIONA:   if (cnt == CW'(TIME - 1)) state_nx = S_TRIGGER;
      S_TRIGGER:     if (cnt == CW'(TRIG_CYCLES - 1)) state_nx = S_ESPERA_ECHO;
      S_ESPERA_ECHO: begin
        if (echo_rise)      state_nx = S_MEDE;
        else if (timeout_c) state_nx = S_TRANSMITE;
      end
      S_MEDE:        if (!echo_s || timeout_c) state_nx = S_TRANSMITE;
      S_TRANSMITE:   if (tx_done_c) state_nx = S_FIM;
      S_FIM:         state_nx = ligar ? S_POSICIONA : S_IDLE;
      default:       state_nx = S_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state and transition.
  always_comb begin
    ld_angle_c   = 1'b0;
    meas_start_c = 1'b0;
    latch_c      = 1'b0;
    adv_c        = 1'b0;
    dist_nx_c    = cm_bcd;
    idx_nx_c     = idx;
    dir_nx_c     = dir_up;
    case (state)
      S_IDLE:        ld_angle_c = (state_nx == S_POSICIONA);
      S_ESPERA_ECHO: begin
        meas_start_c = (state_nx == S_MEDE);
        latch_c      = (state_nx == S_TRANSMITE);
        dist_nx_c    = 12'h999;
      end
      S_MEDE: begin
        latch_c = (state_nx == S_TRANSMITE);
        if (echo_s) dist_nx_c = 12'h999;
      end
      S_FIM: begin
        adv_c      = 1'b1;
        ld_angle_c = (state_nx == S_POSICIONA);
        if (dir_up) begin
          if (idx == 3'd7) begin idx_nx_c = 3'd6; dir_nx_c = 1'b0; end
          else idx_nx_c = idx + 3'd1;
        end else begin
          if (idx == 3'd0) begin idx_nx_c = 3'd1; dir_nx_c = 1'b1; end
          else idx_nx_c = idx - 3'd1;
        end
      end
      default: ;
    endcase
  end

  assign ang_idx_c = adv_c ? idx_nx_c : idx;

  // Shared phase timer, restarted on every state change.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 cnt <= '0;
    else if (state != state_nx) cnt <= '0;
    else                        cnt <= cnt + CW'(1);
  end

  // Echo synchroniser plus edge history.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
      echo_d <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  // Echo width to centimetres; half-period preload rounds to nearest.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc    <= '0;
      cm_bcd   <= '0;
      dist_bcd <= '0;
    end else begin
      if (meas_start_c) begin
        presc  <= PRW'(CM_HALF);
        cm_bcd <= '0;
      end else if (state == S_MEDE && echo_s) begin
        if (presc == PRW'(CM_DIV - 1)) begin
          presc  <= '0;
          cm_bcd <= bcd_inc(cm_bcd);
        end else begin
          presc <= presc + PRW'(1);
        end
      end
      if (latch_c) dist_bcd <= dist_nx_c;
    end
  end

  // Sweep position and the angle reported for the current position.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx     <= 3'd0;
      dir_up  <= 1'b1;
      ang_bcd <= '0;
    end else begin
      if (adv_c) begin
        idx    <= idx_nx_c;
        dir_up <= dir_nx_c;
      end
      if (ld_angle_c) ang_bcd <= ang_of(ang_idx_c);
    end
  end

  // Free-running servo PWM; high time picked up at each frame boundary.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pwm_cnt <= '0;
      pwm_hi  <= high_of(3'd0);
      pwm     <= 1'b0;
    end else begin
      if (pwm_cnt == PW'(PWM_PERIOD - 1)) begin
        pwm_cnt <= '0;
        pwm_hi  <= high_of(idx);
      end else begin
        pwm_cnt <= pwm_cnt + PW'(1);
      end
      pwm <= (pwm_cnt < pwm_hi);
    end
  end

  // UART transmitter for the 8-character report.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_sh        <= '1;
      tx_bit       <= '0;
      tx_baud      <= '0;
      tx_chr       <= '0;
      saida_serial <= 1'b1;
    end else begin
      if (latch_c) begin
        tx_sh   <= tx_frame(tx_char(3'd0, ang_bcd, dist_bcd));
        tx_bit  <= '0;
        tx_baud <= '0;
        tx_chr  <= '0;
      end else if (state == S_TRANSMITE) begin
        if (tx_bit_end) begin
          tx_baud <= '0;
          if (tx_bit == 4'd10) begin
            tx_bit <= '0;
            tx_chr <= tx_chr + 3'd1;
            tx_sh  <= tx_frame(tx_char(tx_chr + 3'd1, ang_bcd, dist_bcd));
          end else begin
            tx_bit <= tx_bit + 4'd1;
            tx_sh  <= {1'b1, tx_sh[10:1]};
          end
        end else begin
          tx_baud <= tx_baud + BW'(1);
        end
      end
      saida_serial <= (state == S_TRANSMITE) ? tx_sh[0] : 1'b1;
    end
  end

  // Registered trigger / end-of-position pulses and display refresh.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trigger     <= 1'b0;
      fim_posicao <= 1'b0;
      display0    <= 7'b1000000;
      display1    <= 7'b1000000;
      display2    <= 7'b1000000;
      display3    <= 7'b1000000;
      display4    <= 7'b1000000;
      display5    <= 7'b1000000;
    end else begin
      trigger     <= (state_nx == S_TRIGGER);
      fim_posicao <= (state_nx == S_FIM);
      if (latch_c) begin
        display0 <= seg7(dist_nx_c[3:0]);
        display1 <= seg7(dist_nx_c[7:4]);
        display2 <= seg7(dist_nx_c[11:8]);
      end
      if (ld_angle_c) begin
        display3 <= seg7(ang_of(ang_idx_c)[3:0]);
        display4 <= seg7(ang_of(ang_idx_c)[7:4]);
        display5 <= seg7(ang_of(ang_idx_c)[11:8]);
      end
    end
  end

endmodule

// File: tb/tb_exp5_sonar.sv
// Directed bench for exp5_sonar with shortened timing constants.
module tb_exp5_sonar;

  localparam int TIME    = 1000;
  localparam int TIMEOUT = 3000;
  localparam int TRIG    = 500;
  localparam int BIT     = 16;
  localparam int CM_DIV  = 20;
  localparam int CM_HALF = 10;
  localparam int PERIOD  = 4000;
  localparam int PMIN    = 500;

  localparam logic [6:0] SEG0 = 7'b1000000;
  localparam logic [6:0] SEG1 = 7'b1111001;
  localparam logic [6:0] SEG4 = 7'b0011001;
  localparam logic [6:0] SEG7 = 7'b1111000;
  localparam logic [6:0] SEG8 = 7'b0000000;

  logic       clock, reset, ligar, echo;
  logic       trigger, pwm, saida_serial, fim_posicao;
  logic [6:0] display0, display1, display2, display3, display4, display5;

  int errors = 0;
  int checks = 0;

  exp5_sonar #(
    .TIME(TIME), .TIMEOUT(TIMEOUT), .TRIG_CYCLES(TRIG), .BIT_CYCLES(BIT),
    .CM_DIV(CM_DIV), .CM_HALF(CM_HALF), .PWM_PERIOD(PERIOD), .PWM_MIN(PMIN)
  ) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .echo(echo),
    .trigger(trigger), .pwm(pwm), .saida_serial(saida_serial), .fim_posicao(fim_posicao),
    .display0(display0), .display1(display1), .display2(display2),
    .display3(display3), .display4(display4), .display5(display5)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Receive one 7O2 character; ok drops on bad start/parity/stop or no start bit.
  task automatic uart_rx(output logic [7:0] ch, output logic ok);
    int t;
    ok = 1'b1;
    ch = 8'h00;
    t  = 0;
    while (saida_serial !== 1'b0 && t < 5000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 5000) begin
      ok = 1'b0;
      return;
    end
    repeat (BIT / 2) @(negedge clock);
    if (saida_serial !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 7; i++) begin
      repeat (BIT) @(negedge clock);
      ch[i] = saida_serial;
    end
    repeat (BIT) @(negedge clock);
    if ((^ch[6:0] ^ saida_serial) !== 1'b1) ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      repeat (BIT) @(negedge clock);
      if (saida_serial !== 1'b1) ok = 1'b0;
    end
  endtask

  // One sweep position: trigger, optional echo of w cycles, frame, end pulse.
  task automatic run_position(input int w, input bit early, input bit stop_tx,
                              input logic [63:0] exp_frame, input string tag);
    int t, tw;
    logic [63:0] fr;
    logic [7:0]  ch;
    logic        ok, all_ok;
    t = 0;
    while (trigger !== 1'b1 && t < 20000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 20000) begin
      check({tag, " trigger_seen"}, 64'(trigger), 64'd1);
      return;
    end
    tw = 0;
    while (trigger === 1'b1 && tw < 2000) begin
      tw++;
      if (early && tw == 100) echo = 1'b1;
      @(negedge clock);
    end
    check({tag, " trigger_width"}, 64'(tw), 64'(TRIG));
    if (early) begin
      repeat (200) @(negedge clock);
      echo = 1'b0;
    end
    repeat (50) @(negedge clock);
    if (w > 0) begin
      echo = 1'b1;
      repeat (w) @(negedge clock);
      echo = 1'b0;
    end
    fr     = '0;
    all_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      uart_rx(ch, ok);
      if (k == 0 && stop_tx) ligar = 1'b0;
      fr     = {fr[55:0], ch};
      all_ok = all_ok & ok;
    end
    check({tag, " frame"}, fr, exp_frame);
    check({tag, " framing"}, 64'(all_ok), 64'd1);
    t = 0;
    while (fim_posicao !== 1'b1 && t < 300) begin
      @(negedge clock);
      t++;
    end
    check({tag, " fim_pulse"}, 64'(fim_posicao), 64'd1);
    @(negedge clock);
    check({tag, " fim_one_cycle"}, 64'(fim_posicao), 64'd0);
  endtask

  task automatic measure_pwm(output int hi);
    int t;
    t  = 0;
    hi = 0;
    while (pwm !== 1'b0 && t < 20000) begin @(negedge clock); t++; end
    while (pwm !== 1'b1 && t < 20000) begin @(negedge clock); t++; end
    while (pwm === 1'b1 && hi < 20000) begin @(negedge clock); hi++; end
  endtask

  initial begin
    int hi, trig_cnt;
    reset = 1'b1;
    ligar = 1'b0;
    echo  = 1'b0;
    #15 reset = 1'b0;
    repeat (100) @(negedge clock);
    check("reset pwm", 64'(pwm), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    check("reset trigger", 64'(trigger), 64'd0);
    check("reset serial", 64'(saida_serial), 64'd1);
    check("reset fim", 64'(fim_posicao), 64'd0);
    check("reset display0", 64'(display0), 64'(SEG0));
    check("reset display1", 64'(display1), 64'(SEG0));
    check("reset display2", 64'(display2), 64'(SEG0));
    check("reset display3", 64'(display3), 64'(SEG0));
    check("reset display4", 64'(display4), 64'(SEG0));
    check("reset display5", 64'(display5), 64'(SEG0));

    // 20 deg: 500 + 20*500/180 = 555 cycles high while idle.
    measure_pwm(hi);
    check("pwm_020", 64'(hi), 64'd555);

    ligar = 1'b1;
    run_position(2000, 1'b0, 1'b0, "020,100#", "pos1");
    run_position(2006, 1'b0, 1'b0, "040,100#", "pos2");
    run_position(1480, 1'b0, 1'b0, "060,074#", "pos3");
    // Distance 074 latched; angle already moved to 080 for the next position.
    check("pos3 display0", 64'(display0), 64'(SEG4));
    check("pos3 display1", 64'(display1), 64'(SEG7));
    check("pos3 display2", 64'(display2), 64'(SEG0));
    check("pos3 display3", 64'(display3), 64'(SEG0));
    check("pos3 display4", 64'(display4), 64'(SEG8));
    check("pos3 display5", 64'(display5), 64'(SEG0));
    run_position(1496, 1'b0, 1'b0, "080,075#", "pos4");
    run_position(600,  1'b1, 1'b0, "100,030#", "pos5_early_echo");
    run_position(5,    1'b0, 1'b0, "120,000#", "pos6");
    run_position(200,  1'b0, 1'b0, "140,010#", "pos7");
    run_position(200,  1'b0, 1'b0, "160,010#", "pos8");
    run_position(200,  1'b0, 1'b0, "140,010#", "pos9");
    run_position(200,  1'b0, 1'b0, "120,010#", "pos10");
    run_position(200,  1'b0, 1'b1, "100,010#", "pos11_stop");

    trig_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (trigger === 1'b1) trig_cnt++;
    end
    check("idle no_trigger", 64'(trig_cnt), 64'd0);
    check("idle display0", 64'(display0), 64'(SEG0));
    check("idle display1", 64'(display1), 64'(SEG1));
    check("idle display3", 64'(display3), 64'(SEG0));
    check("idle display5", 64'(display5), 64'(SEG1));
    // Next position is 80 deg: 500 + 80*500/180 = 722 cycles high.
    measure_pwm(hi);
    check("pwm_080", 64'(hi), 64'd722);

`ifdef SONAR_TIMEOUT_EN
    ligar = 1'b1;
    run_position(0, 1'b0, 1'b1, "080,999#", "timeout");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
